// File: rtl/reg_writeback_queue_if.sv
// Write-back request, drain and forwarding signals of reg_writeback_queue.
// The CPU side is the master; the queue is the slave.
interface reg_writeback_queue_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              aluValid;
  logic [4:0]        aluReg;
  logic [DATA_W-1:0] aluData;
  logic              memValid;
  logic [4:0]        memReg;
  logic [DATA_W-1:0] memData;
  logic              stall;
  logic [4:0]        lookupReg1;
  logic [4:0]        lookupReg2;
  logic              hit1;
  logic              hit2;
  logic [DATA_W-1:0] fwdData1;
  logic [DATA_W-1:0] fwdData2;
  logic [4:0]        writeReg;
  logic [DATA_W-1:0] writeData;
  logic              regWrite;
  logic              ready;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
  logic              overflow;

  modport master (
    output aluValid, aluReg, aluData, memValid, memReg, memData, stall,
           lookupReg1, lookupReg2,
    input  hit1, hit2, fwdData1, fwdData2, writeReg, writeData, regWrite,
           ready, count, empty, full, overflow
  );

  modport slave (
    input  aluValid, aluReg, aluData, memValid, memReg, memData, stall,
           lookupReg1, lookupReg2,
    output hit1, hit2, fwdData1, fwdData2, writeReg, writeData, regWrite,
           ready, count, empty, full, overflow
  );
endinterface

// File: rtl/reg_writeback_queue.sv
// Register write-back FIFO: merges ALU and load results, drains one write per
// cycle into the register file and forwards in-flight values to decode.
module reg_writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                  clock_in,
  input  logic                  reset,
  reg_writeback_queue_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [4:0]        r_reg_mem  [DEPTH];
  logic [DATA_W-1:0] r_data_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;
  logic              r_reg_write;
  logic [4:0]        r_write_reg;
  logic [DATA_W-1:0] r_write_data;

  logic              w_mem_req;
  logic              w_alu_req;
  logic              w_mem_push;
  logic              w_alu_push;
  logic              w_drop;
  logic              w_pop;
  logic [CNT_W-1:0]  w_free;
  logic [CNT_W-1:0]  w_push_cnt;
  logic [PTR_W-1:0]  w_alu_slot;

  assign w_mem_req  = bus.memValid && (bus.memReg != 5'd0);
  assign w_alu_req  = bus.aluValid && (bus.aluReg != 5'd0);
  // Free space is judged before this cycle's pop; mem claims a slot first.
  assign w_free     = CNT_W'(DEPTH) - r_count;
  assign w_mem_push = w_mem_req && (w_free != '0);
  assign w_alu_push = w_alu_req && ((w_free - CNT_W'(w_mem_push)) != '0);
  assign w_drop     = (w_mem_req && !w_mem_push) || (w_alu_req && !w_alu_push);
  assign w_pop      = (r_count != '0) && !bus.stall;
  assign w_push_cnt = CNT_W'(w_mem_push) + CNT_W'(w_alu_push);
  assign w_alu_slot = r_wr_ptr + PTR_W'(w_mem_push);

  always_ff @(posedge clock_in) begin
    if (w_mem_push) begin
      r_reg_mem[r_wr_ptr]  <= bus.memReg;
      r_data_mem[r_wr_ptr] <= bus.memData;
    end
    if (w_alu_push) begin
      r_reg_mem[w_alu_slot]  <= bus.aluReg;
      r_data_mem[w_alu_slot] <= bus.aluData;
    end
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_overflow   <= 1'b0;
      r_reg_write  <= 1'b0;
      r_write_reg  <= 5'd0;
      r_write_data <= '0;
    end else begin
      r_wr_ptr    <= r_wr_ptr + PTR_W'(w_push_cnt);
      r_rd_ptr    <= r_rd_ptr + PTR_W'(w_pop);
      r_count     <= r_count + w_push_cnt - CNT_W'(w_pop);
      r_reg_write <= w_pop;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      if (w_pop) begin
        r_write_reg  <= r_reg_mem[r_rd_ptr];
        r_write_data <= r_data_mem[r_rd_ptr];
      end
    end
  end

  // Scan oldest to youngest so the last match (youngest) overrides.
  for (genvar gi = 0; gi < 2; gi++) begin : g_lookup
    logic [4:0]        w_query;
    logic              w_hit;
    logic [DATA_W-1:0] w_fwd;

    assign w_query = (gi == 0) ? bus.lookupReg1 : bus.lookupReg2;

    always_comb begin
      logic [PTR_W-1:0] idx;
      w_hit = 1'b0;
      w_fwd = '0;
      idx   = '0;
      if (r_reg_write && (r_write_reg == w_query)) begin
        w_hit = 1'b1;
        w_fwd = r_write_data;
      end
      for (int k = 0; k < DEPTH; k++) begin
        idx = r_rd_ptr + PTR_W'(k);
        if ((k < int'(r_count)) && (r_reg_mem[idx] == w_query)) begin
          w_hit = 1'b1;
          w_fwd = r_data_mem[idx];
        end
      end
      if (w_query == 5'd0) begin
        w_hit = 1'b0;
        w_fwd = '0;
      end
    end
  end

  assign bus.hit1      = g_lookup[0].w_hit;
  assign bus.fwdData1  = g_lookup[0].w_fwd;
  assign bus.hit2      = g_lookup[1].w_hit;
  assign bus.fwdData2  = g_lookup[1].w_fwd;
  assign bus.regWrite  = r_reg_write;
  assign bus.writeReg  = r_write_reg;
  assign bus.writeData = r_write_data;
  assign bus.count     = r_count;
  assign bus.empty     = (r_count == '0);
  assign bus.full      = (r_count == CNT_W'(DEPTH));
  assign bus.ready     = (r_count <= CNT_W'(DEPTH - 2));
  assign bus.overflow  = r_overflow;
endmodule

// File: doc/reg_writeback_queue.md
# reg_writeback_queue

Buffers register write-back requests from the ALU and memory paths of the CPU and drains them, one per cycle, into the write port of the 32×32 register file. Register-file writes happen on the falling edge of `clock_in`. This block updates its outputs on the rising edge, so `writeReg`/`writeData`/`regWrite` are stable for the register file's falling-edge sample. It also gives the decode stage a forwarding lookup over all pending writes, so reads of in-flight registers get current data.

## Interface
- `DEPTH`, 4, FIFO entries; power of two, ≥ 2
- `DATA_W`, 32, data width
- `clock_in`  in  1  system clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `aluValid`  in  1  ALU write request this cycle
- `aluReg`  in  5  ALU destination register
- `aluData`  in  DATA_W  ALU result
- `memValid`  in  1  load write request this cycle
- `memReg`  in  5  load destination register
- `memData`  in  DATA_W  load data
- `stall`  in  1  hold the drain; no pop this cycle
- `lookupReg1`, `lookupReg2`  in  5 each  forwarding query addresses
- `hit1`, `hit2`  out  1 each  a pending write matches the query
- `fwdData1`, `fwdData2`  out  DATA_W each  forwarded data; 0 when there is no hit
- `writeReg`  out  5  register-file write address (registered)
- `writeData`  out  DATA_W  register-file write data (registered)
- `regWrite`  out  1  register-file write enable (registered)
- `ready`  out  1  `count` ≤ DEPTH−2, so two requests can be accepted
- `count`  out  log2(DEPTH)+1  occupied entries
- `empty`, `full`  out  1 each  `count`==0 / `count`==DEPTH
- `overflow`  out  1  sticky; a request was dropped

## Operation
- **Enqueue**
  - A request is accepted when its valid is high and its register is nonzero.
  - Requests with register 0 are discarded silently, are never stored, and do not set `overflow`.
- **Same-cycle requests**
  - When both requests are accepted in one cycle, the mem request is enqueued first (it is the older instruction) and the ALU request second.
- **Dropped requests**
  - A valid, nonzero request that finds no free slot is dropped and sets `overflow`. Free slots are evaluated after the same-cycle mem enqueue and before this cycle's pop.
  - `overflow` clears only on reset.
- **Drain**
  - When `count`>0 and `stall`=0: the head entry is popped, and `writeReg`/`writeData` are loaded from it with `regWrite`=1.
  - Otherwise `regWrite`=0, and `writeReg`/`writeData` hold their last values.
- **Simultaneous pop and push**
  - Allowed in the same cycle.
  - Next `count` = `count` + accepted pushes − pop.
  - Read and write pointers wrap modulo DEPTH.
- **Forwarding (combinational)**
  - Search set: the output stage (only when `regWrite`=1), which is the oldest, plus every valid FIFO entry.
  - The youngest match wins.
  - A query of register 0 never hits.
- **Outputs**
  - `ready`, `empty`, `full`, and `count` derive from registered `count` only.

## Timing
- Reset (asynchronous) takes effect immediately:
  - `regWrite`=0, `writeReg`=0, `writeData`=0
  - `count`=0, `empty`=1, `full`=0, `ready`=1, `overflow`=0
  - `hit1`=`hit2`=0, `fwdData1`=`fwdData2`=0
  - Pending entries are discarded.
- A reset asserted mid-drain cancels the write in progress: `regWrite` falls without waiting for a clock edge.
- Latency:
  - A request sampled at rising edge E is in the FIFO after E.
  - With an empty queue and `stall`=0, `regWrite`=1 for that request during the cycle after edge E+1.
  - The register file commits it on that cycle's falling edge.
- Forwarding:
  - A request becomes visible to the lookup in the cycle after its enqueue edge.
  - It stays visible through the cycle in which `regWrite` presents it.
- Throughput: one write per cycle. `regWrite` is asserted for exactly one cycle per popped entry.
- `stall` is sampled at the rising edge. `stall`=1 freezes the head entry but does not block enqueue.

## Test plan
- **Reset, then single request:** reset, then ALU request reg 5, data 0x0000_00AA → `regWrite`=1, `writeReg`=5, `writeData`=0xAA for exactly one cycle, two edges after the request; `count` returns to 0.
- **Same-cycle ordering:** in one cycle, mem reg 3 = 0x11 and ALU reg 3 = 0x22 → writes reg 3 = 0x11, then reg 3 = 0x22 on consecutive cycles; lookup of reg 3 between them returns 0x22.
- **Register 0 filtering:** ALU request reg 0, data 0xFFFF → nothing enqueued, `count`=0, `overflow`=0; lookup of reg 0 gives `hit`=0.
- **Fill under stall:** with `stall`=1, push 4 single requests on regs 1..4 → `full`=1, `ready`=0. A 5th request (reg 9) is dropped and `overflow`=1. Release `stall` → four writes to regs 1..4 in order, then `empty`=1.
- **Pointer wrap:** push and pop continuously for 10 cycles with distinct data 0x100+i → writes appear in order, none lost, `overflow` stays 0.
- **Reset mid-operation:** reset while `count`=3 and `regWrite`=1 → `regWrite`=0 immediately. After release, no stale writes occur and lookups all return `hit`=0.
